registers: RTL and testbench
============================

// Module: registers
//
// PURPOSE
//  - General-purpose register file for the tiny16 datapath: 8 x 16-bit registers.
//  - Two read ports (src, dst), both addressed by instruction fields; one write port shares the dst_sel address.
//  - Sits between instruction decode and the ALU. src/dst feed ALU operands; `in` carries the ALU/load result back.
//
// PARAMETERS
//  - DATA_WIDTH  16  width of each register and of in/src/dst
//  - ADDR_WIDTH  3   select width; register count NUM_REGS = 2**ADDR_WIDTH (8)
//
// PORTS
//  - clk      in   1           single clock, all state updates on rising edge
//  - rst      in   1           asynchronous, active-low reset (0 = reset asserted)
//  - src_sel  in   ADDR_WIDTH  register index for src read port
//  - dst_sel  in   ADDR_WIDTH  register index for dst read port AND write port
//  - out_en   in   1           1 = capture reg[src_sel] -> src and reg[dst_sel] -> dst at clk edge
//  - in_en    in   1           1 = write `in` into reg[dst_sel] at clk edge
//  - in       in   DATA_WIDTH  write data
//  - src      out  DATA_WIDTH  registered read data, port A
//  - dst      out  DATA_WIDTH  registered read data, port B
//
// BEHAVIOUR
//  - Reset (rst=0, asynchronous): all NUM_REGS registers clear to 0; src and dst clear to 0.
//    While rst=0, clock edges have no effect. Release is synchronous to the next rising edge.
//  - Write: at a rising edge with in_en=1, reg[dst_sel] <= in. Latency 1 cycle.
//    With in_en=0, no register changes.
//  - Read:
//    - At a rising edge with out_en=1: src <= reg[src_sel]; dst <= reg[dst_sel]. Values are valid after that edge (1-cycle latency).
//    - With out_en=0: src and dst hold their last values. They are not combinational and do not follow select changes.
//  - Register 0 is an ordinary storage register. It is not hardwired to zero.
//  - src_sel == dst_sel: both outputs capture the same register value.
//  - Same-edge write and read (in_en=1, out_en=1): read-before-write.
//    - dst (and src if src_sel==dst_sel) captures the pre-write contents.
//    - The new value is visible on the next out_en edge. No bypass path.
//  - All selects are full-range (0..NUM_REGS-1). There are no illegal indices and no wrap logic.
//  - Reset asserted mid-operation aborts any pending write. State returns to all-zero immediately.
//  - No X propagation: every register has a defined reset value.
//
// STRUCTURE
//  - Shared package (tiny16_pkg): DATA_WIDTH, ADDR_WIDTH, NUM_REGS constants, plus word_t / reg_idx_t typedefs reused by ALU and decode.
//  - Single flat module: storage array + write decode + two read muxes with output registers.
//  - No sub-module required. Optionally factor the read mux + output register into `regfile_read_port`, instantiated twice.
//
// TESTING
//  - Reset, then out_en=1 with src_sel=0, dst_sel=1 for one edge -> src=0, dst=0.
//  - Write 10 to r2 and 20 to r3 (in_en=1, one edge each), then out_en=1 with src_sel=2, dst_sel=3 -> src=10, dst=20 after that edge.
//  - Write all 8 registers with 0x1000+i, then read every (src_sel, dst_sel) pair -> each output matches its index. Confirms no aliasing and that r0 holds 0x1000.
//  - Same edge: in_en=1, out_en=1, dst_sel=4, in=0xBEEF, r4 previously 0x0011 -> dst=0x0011. Next out_en edge -> dst=0xBEEF.
//  - out_en=0 while changing src_sel/dst_sel and writing -> src/dst unchanged. in_en=0 with `in` toggling -> no register changes.
//  - Pull rst low asynchronously between edges after writing 0xFFFF to r7 -> src/dst go to 0 immediately. After release, reading r7 returns 0.

Source files
------------

// File: rtl/tiny16_pkg.sv
// Shared tiny16 datapath constants and types, reused by the register file, ALU and decode.
package tiny16_pkg;
    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 3;
    localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef logic [ADDR_WIDTH-1:0] reg_idx_t;
endpackage

// File: rtl/registers_if.sv
// Register-file access bus: read/write selects, enables, write data and both read outputs.
interface registers_if;
    import tiny16_pkg::*;

    reg_idx_t src_sel;
    reg_idx_t dst_sel;
    logic     out_en;
    logic     in_en;
    word_t    in;
    word_t    src;
    word_t    dst;

    modport master (
        output src_sel, dst_sel, out_en, in_en, in,
        input  src, dst
    );

    modport slave (
        input  src_sel, dst_sel, out_en, in_en, in,
        output src, dst
    );
endinterface

// File: rtl/regfile_read_port.sv
// One register-file read port: select mux feeding an output register that only loads on out_en.
module regfile_read_port
    import tiny16_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     out_en,
    input  reg_idx_t sel,
    input  word_t    regs [NUM_REGS],
    output word_t    q
);
    word_t q_reg;

    // regs carries pre-edge contents, so a same-edge write is not seen here (read-before-write).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_reg <= '0;
        end else if (out_en) begin
            q_reg <= regs[sel];
        end
    end

    assign q = q_reg;
endmodule

// File: rtl/registers.sv
// tiny16 general-purpose register file: 8 x 16-bit, two registered read ports, one write port on dst_sel.
module registers
    import tiny16_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    registers_if.slave  bus
);
    word_t regs_reg [NUM_REGS];
    word_t src_q;
    word_t dst_q;

    // Each register owns its write decode; r0 is ordinary storage.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    regs_reg[gi] <= '0;
                end else if (bus.in_en && (bus.dst_sel == reg_idx_t'(gi))) begin
                    regs_reg[gi] <= bus.in;
                end
            end
        end
    endgenerate

    regfile_read_port u_src_port (
        .clk    (clk),
        .rst    (rst),
        .out_en (bus.out_en),
        .sel    (bus.src_sel),
        .regs   (regs_reg),
        .q      (src_q)
    );

    regfile_read_port u_dst_port (
        .clk    (clk),
        .rst    (rst),
        .out_en (bus.out_en),
        .sel    (bus.dst_sel),
        .regs   (regs_reg),
        .q      (dst_q)
    );

    assign bus.src = src_q;
    assign bus.dst = dst_q;
endmodule

// File: tb/tb_registers.sv
// Directed-vector bench for the tiny16 register file, plus hand-written async-reset sequence.
module tb_registers;
    import tiny16_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    registers_if bus ();

    registers dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string    name;
        reg_idx_t src_sel;
        reg_idx_t dst_sel;
        logic     out_en;
        logic     in_en;
        word_t    din;
        word_t    exp_src;
        word_t    exp_dst;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string n, int s, int d, logic oe, logic ie,
                                int din, int es, int ed);
        vec_t v;
        v.name    = n;
        v.src_sel = reg_idx_t'(s);
        v.dst_sel = reg_idx_t'(d);
        v.out_en  = oe;
        v.in_en   = ie;
        v.din     = word_t'(din);
        v.exp_src = word_t'(es);
        v.exp_dst = word_t'(ed);
        vecs.push_back(v);
    endfunction

    task automatic check(string n, word_t act, word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", n, act, exp);
        end
    endtask

    task automatic drive(reg_idx_t s, reg_idx_t d, logic oe, logic ie, word_t din);
        bus.src_sel = s;
        bus.dst_sel = d;
        bus.out_en  = oe;
        bus.in_en   = ie;
        bus.in      = din;
    endtask

    initial begin
        // Reset-state, write, full pair sweep and read-before-write vectors.
        add("rst_read",  0, 1, 1, 0, 0,      0,      0);
        add("wr_r2",     0, 2, 0, 1, 10,     0,      0);
        add("wr_r3",     0, 3, 0, 1, 20,     0,      0);
        add("rd_r2_r3",  2, 3, 1, 0, 0,      10,     20);
        for (int i = 0; i < NUM_REGS; i++)
            add($sformatf("wr_all_r%0d", i), 0, i, 0, 1, 'h1000 + i, 10, 20);
        for (int s = 0; s < NUM_REGS; s++)
            for (int d = 0; d < NUM_REGS; d++)
                add($sformatf("pair_s%0d_d%0d", s, d), s, d, 1, 0, 0,
                    'h1000 + s, 'h1000 + d);
        add("wr_r4_0011", 0, 4, 0, 1, 'h0011, 'h1007, 'h1007);
        add("rbw_same",   4, 4, 1, 1, 'hBEEF, 'h0011, 'h0011);
        add("rbw_next",   4, 4, 1, 0, 0,      'hBEEF, 'hBEEF);
        add("hold_wr_r5", 0, 5, 0, 1, 'h5555, 'hBEEF, 'hBEEF);
        add("hold_tog_a", 1, 6, 0, 0, 'h1234, 'hBEEF, 'hBEEF);
        add("hold_tog_b", 2, 6, 0, 0, 'hEDCB, 'hBEEF, 'hBEEF);
        add("rd_r5_r6",   5, 6, 1, 0, 0,      'h5555, 'h1006);
        add("rd_r0_r2",   0, 2, 1, 0, 0,      'h1000, 'h1002);
        add("wr_r7_ffff", 0, 7, 0, 1, 'hFFFF, 'h1000, 'h1002);
        add("rd_r7",      7, 7, 1, 0, 0,      'hFFFF, 'hFFFF);

        rst = 1'b0;
        drive('0, '0, 1'b0, 1'b0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_src", bus.src, 16'h0000);
        check("reset_dst", bus.dst, 16'h0000);
        rst = 1'b1;

        foreach (vecs[k]) begin
            drive(vecs[k].src_sel, vecs[k].dst_sel, vecs[k].out_en, vecs[k].in_en, vecs[k].din);
            @(posedge clk);
            #1;
            $display("vec %0d %s src_sel=%0d dst_sel=%0d oe=%b ie=%b in=%h -> src=%h dst=%h",
                     k, vecs[k].name, vecs[k].src_sel, vecs[k].dst_sel, vecs[k].out_en,
                     vecs[k].in_en, vecs[k].din, bus.src, bus.dst);
            check({vecs[k].name, "_src"}, bus.src, vecs[k].exp_src);
            check({vecs[k].name, "_dst"}, bus.dst, vecs[k].exp_dst);
            @(negedge clk);
        end

        // Asynchronous reset between edges; outputs must clear without a clock edge.
        drive(3'd7, 3'd1, 1'b1, 1'b1, 16'hAAAA);
        #2;
        rst = 1'b0;
        #1;
        $display("async reset asserted -> src=%h dst=%h", bus.src, bus.dst);
        check("async_rst_src", bus.src, 16'h0000);
        check("async_rst_dst", bus.dst, 16'h0000);
        @(posedge clk);
        #1;
        $display("edge during reset -> src=%h dst=%h", bus.src, bus.dst);
        check("rst_edge_src", bus.src, 16'h0000);
        check("rst_edge_dst", bus.dst, 16'h0000);
        @(negedge clk);
        drive(3'd7, 3'd1, 1'b1, 1'b0, 16'h0000);
        rst = 1'b1;
        @(posedge clk);
        #1;
        $display("post-reset read r7/r1 -> src=%h dst=%h", bus.src, bus.dst);
        check("post_rst_r7", bus.src, 16'h0000);
        check("post_rst_r1", bus.dst, 16'h0000);
        @(negedge clk);
        drive(3'd4, 3'd5, 1'b1, 1'b0, 16'h0000);
        @(posedge clk);
        #1;
        $display("post-reset read r4/r5 -> src=%h dst=%h", bus.src, bus.dst);
        check("post_rst_r4", bus.src, 16'h0000);
        check("post_rst_r5", bus.dst, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
